// File: rtl/aes_key_iterator.sv
// AES-128 round-key iterator: steps the key schedule one round per clock,
// forward from rk0 or in reverse from rk10, with an automatic run to rk10.

module aes_sbox (
    input  logic [7:0] in_byte,
    input  logic       dec,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    logic [7:0] fwd_inv;
    logic [7:0] inv_aff;

    always_comb begin
        fwd_inv  = gf_inv(in_byte);
        inv_aff  = rotl(in_byte, 1) ^ rotl(in_byte, 3) ^ rotl(in_byte, 6) ^ 8'h05;
        out_byte = fwd_inv ^ rotl(fwd_inv, 1) ^ rotl(fwd_inv, 2) ^ rotl(fwd_inv, 3)
                 ^ rotl(fwd_inv, 4) ^ 8'h63;
        if (dec) out_byte = gf_inv(inv_aff);
    end
endmodule

module aes_key_iterator (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [127:0] key_i,
    input  logic         dec_i,
    input  logic         next_i,
    input  logic         calc_last_i,
    output logic [127:0] rk_o,
    output logic [3:0]   rnd_o,
    output logic         key_valid_o,
    output logic         busy_o,
    output logic         done_o
);
    // state | meaning
    // IDLE  | no key loaded
    // HOLD  | key valid, waiting for next_i / calc_last_i
    // AUTO  | forward stepping one round per cycle until round 10
    typedef enum logic [1:0] {IDLE, HOLD, AUTO} state_t;

    state_t       state, state_nx;
    logic [127:0] rk, rk_nx;
    logic [3:0]   rnd, rnd_nx;
    logic         dir, dir_nx;
    logic         done_r, done_nx;

    logic [31:0]  w0, w1, w2, w3, p3, sbox_in, rot_w, sub_w;
    logic [3:0]   rcon_idx;
    logic [7:0]   rcon;
    logic [127:0] fwd_key, rev_key, step_key;

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign w0 = rk[127:96];
    assign w1 = rk[95:64];
    assign w2 = rk[63:32];
    assign w3 = rk[31:0];
    // in reverse, the previous w3 is recovered as w7^w6 before SubWord
    assign p3       = w3 ^ w2;
    assign sbox_in  = dir ? p3 : w3;
    assign rot_w    = {sbox_in[23:0], sbox_in[31:24]};
    assign rcon_idx = dir ? rnd : rnd + 4'd1;
    assign rcon     = rcon_of(rcon_idx);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_w[8*i +: 8]),
            .dec      (1'b0),
            .out_byte (sub_w[8*i +: 8])
        );
    end

    always_comb begin
        logic [31:0] t, n0, n1, n2;
        t  = sub_w ^ {rcon, 24'h0};
        n0 = w0 ^ t;
        n1 = n0 ^ w1;
        n2 = n1 ^ w2;
        fwd_key  = {n0, n1, n2, n2 ^ w3};
        rev_key  = {w0 ^ sub_w ^ {rcon, 24'h0}, w1 ^ w0, w2 ^ w1, p3};
        step_key = dir ? rev_key : fwd_key;
    end

    always_comb begin
        state_nx = state;
        rk_nx    = rk;
        rnd_nx   = rnd;
        dir_nx   = dir;
        done_nx  = 1'b0;
        if (load_i) begin
            rk_nx    = key_i;
            rnd_nx   = dec_i ? 4'd10 : 4'd0;
            dir_nx   = dec_i;
            state_nx = HOLD;
        end else begin
            case (state)
                HOLD: begin
                    if (calc_last_i) begin
                        if (!dir && rnd < 4'd10) state_nx = AUTO;
                        else if (!dir)           done_nx  = 1'b1;
                    end else if (next_i) begin
                        if (!dir && rnd < 4'd10) begin
                            rk_nx  = step_key;
                            rnd_nx = rnd + 4'd1;
                        end else if (dir && rnd > 4'd0) begin
                            rk_nx  = step_key;
                            rnd_nx = rnd - 4'd1;
                        end
                    end
                end
                AUTO: begin
                    rk_nx  = step_key;
                    rnd_nx = rnd + 4'd1;
                    if (rnd == 4'd9) begin
                        state_nx = HOLD;
                        done_nx  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rk     <= '0;
            rnd    <= '0;
            dir    <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nx;
            rk     <= rk_nx;
            rnd    <= rnd_nx;
            dir    <= dir_nx;
            done_r <= done_nx;
        end
    end

    assign rk_o        = rk;
    assign rnd_o       = rnd;
    assign key_valid_o = (state != IDLE);
    assign busy_o      = (state == AUTO);
    assign done_o      = done_r;
endmodule

// File: tb/tb_aes_key_iterator.sv
// Scoreboard bench for aes_key_iterator: stimulus pushes expected output tuples,
// a monitor pops and compares whenever the DUT is stimulated or its outputs move.

module tb_aes_key_iterator;
    logic         clk, rst, load_i, dec_i, next_i, calc_last_i;
    logic [127:0] key_i, rk_o;
    logic [3:0]   rnd_o;
    logic         key_valid_o, busy_o, done_o;

    aes_key_iterator dut (
        .clk(clk), .rst(rst), .load_i(load_i), .key_i(key_i), .dec_i(dec_i),
        .next_i(next_i), .calc_last_i(calc_last_i), .rk_o(rk_o), .rnd_o(rnd_o),
        .key_valid_o(key_valid_o), .busy_o(busy_o), .done_o(done_o)
    );

    localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    int n_cmp = 0;
    int n_mis = 0;
    logic [133:0] exp_q[$];
    logic [3:0]   done_q[$];

    logic [127:0] m_rk;
    logic [3:0]   m_rnd;
    logic         m_dir, m_valid;

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[2047 - 8*x -: 8];
    endfunction

    function automatic logic [31:0] subrot(input logic [31:0] w);
        return {sb(w[23:16]), sb(w[15:8]), sb(w[7:0]), sb(w[31:24])};
    endfunction

    function automatic logic [7:0] rc(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 1; i < r; i++) v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
        return v;
    endfunction

    function automatic logic [127:0] fwd(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] a, b, c, d;
        a = k[127:96] ^ subrot(k[31:0]) ^ {rc(r), 24'h0};
        b = a ^ k[95:64];
        c = b ^ k[63:32];
        d = c ^ k[31:0];
        return {a, b, c, d};
    endfunction

    function automatic logic [127:0] rev(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] p3;
        p3 = k[31:0] ^ k[63:32];
        return {k[127:96] ^ subrot(p3) ^ {rc(r), 24'h0}, k[95:64] ^ k[127:96],
                k[63:32] ^ k[95:64], p3};
    endfunction

    task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // monitor
    initial begin
        logic [133:0] cur, prev;
        logic act;
        prev = '0;
        forever begin
            @(posedge clk);
            act = load_i | next_i | calc_last_i;
            #1;
            cur = {rk_o, rnd_o, key_valid_o, busy_o};
            if (act || cur !== prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_mis++;
                    $display("FAIL unexpected_output: got %h expected none", cur);
                end else chk("out_tuple", cur, exp_q.pop_front());
            end
            prev = cur;
            if (done_o) begin
                if (done_q.size() == 0) begin
                    n_cmp++; n_mis++;
                    $display("FAIL unexpected_done: got rnd %0d expected no pulse", rnd_o);
                end else chk("done_rnd", {130'b0, rnd_o}, {130'b0, done_q.pop_front()});
            end
        end
    end

    task automatic push(input logic b);
        exp_q.push_back({m_rk, m_rnd, m_valid, b});
    endtask

    // drive tasks start at a negedge and end at the next one
    task automatic t_load(input logic [127:0] k, input logic d);
        m_rk = k; m_rnd = d ? 4'd10 : 4'd0; m_dir = d; m_valid = 1'b1;
        push(1'b0);
        load_i = 1'b1; key_i = k; dec_i = d;
        @(negedge clk);
        load_i = 1'b0;
    endtask

    task automatic t_next();
        if (m_valid && !m_dir && m_rnd < 4'd10) begin
            m_rnd = m_rnd + 4'd1; m_rk = fwd(m_rk, m_rnd);
        end else if (m_valid && m_dir && m_rnd > 4'd0) begin
            m_rk = rev(m_rk, m_rnd); m_rnd = m_rnd - 4'd1;
        end
        push(1'b0);
        next_i = 1'b1;
        @(negedge clk);
        next_i = 1'b0;
    endtask

    task automatic t_calc(input logic [3:0] stop);
        if (m_valid && !m_dir && m_rnd < 4'd10) begin
            push(1'b1);
            while (m_rnd < stop) begin
                m_rnd = m_rnd + 4'd1; m_rk = fwd(m_rk, m_rnd);
                push(m_rnd != 4'd10);
            end
            if (m_rnd == 4'd10) done_q.push_back(4'd10);
        end else begin
            push(1'b0);
            if (m_valid && !m_dir) done_q.push_back(4'd10);
        end
        calc_last_i = 1'b1;
        @(negedge clk);
        calc_last_i = 1'b0;
    endtask

    task automatic wait_rnd(input logic [3:0] r);
        int i;
        for (i = 0; i < 20 && rnd_o != r; i++) @(negedge clk);
        if (rnd_o != r) begin
            n_cmp++; n_mis++;
            $display("FAIL wait_rnd: got %0d expected %0d", rnd_o, r);
        end
    endtask

    initial begin
        int busy_cnt;
        logic [127:0] key;
        rst = 1'b1; load_i = 1'b0; dec_i = 1'b0; next_i = 1'b0; calc_last_i = 1'b0;
        key_i = '0;
        m_rk = '0; m_rnd = '0; m_dir = 1'b0; m_valid = 1'b0;
        #12;
        chk("reset", {rk_o, rnd_o, key_valid_o, busy_o, done_o}, '0);
        @(negedge clk);
        rst = 1'b0;

        t_next();
        t_calc(4'd10);

        // forward single step
        t_load(K0, 1'b0);
        t_next();
        chk("fwd_rk1", {2'b0, rk_o, rnd_o}, {2'b0, K1, 4'd1});

        // automatic run to rk10
        t_load(K0, 1'b0);
        t_calc(4'd10);
        busy_cnt = busy_o ? 1 : 0;
        repeat (14) begin
            @(negedge clk);
            if (busy_o) busy_cnt++;
        end
        chk("busy_cycles", 134'(busy_cnt), 134'd10);
        chk("auto_rk10", {2'b0, rk_o, rnd_o}, {2'b0, K10, 4'd10});
        t_calc(4'd10);
        t_next();

        // reverse walk to rk0, then one step past the end
        t_load(K10, 1'b1);
        repeat (10) t_next();
        chk("rev_rk0", {2'b0, rk_o, rnd_o}, {2'b0, K0, 4'd0});
        t_calc(4'd10);
        t_next();
        chk("rev_end_hold", {2'b0, rk_o, rnd_o}, {2'b0, K0, 4'd0});

        // load aborts AUTO at round 4
        t_load(K0, 1'b0);
        t_calc(4'd4);
        wait_rnd(4'd4);
        t_load('0, 1'b0);
        repeat (12) @(negedge clk);
        chk("abort_state", {rk_o, rnd_o, key_valid_o, busy_o}, {128'h0, 4'd0, 1'b1, 1'b0});

        // asynchronous reset mid-AUTO
        t_load(K0, 1'b0);
        t_calc(4'd3);
        wait_rnd(4'd3);
        m_rk = '0; m_rnd = '0; m_dir = 1'b0; m_valid = 1'b0;
        push(1'b0);
        #2 rst = 1'b1;
        #1 chk("async_reset", {rk_o, rnd_o, key_valid_o, busy_o, done_o}, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        t_next();
        t_calc(4'd10);
        repeat (12) @(negedge clk);

        // random keys: forward then reverse round trip
        for (int n = 0; n < 3; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            t_load(key, 1'b0);
            repeat (10) t_next();
            t_load(m_rk, 1'b1);
            repeat (10) t_next();
            chk("round_trip", {2'b0, rk_o, rnd_o}, {2'b0, key, 4'd0});
        end

        repeat (4) @(negedge clk);
        chk("exp_q_empty", 134'(exp_q.size()), '0);
        chk("done_q_empty", 134'(done_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
